// File: rtl/wb_seg.sv
// rtl/wb_seg.sv - writeback stage: decodes retiring instructions and drives the register-file write port
module wb_seg #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_IR,
  input  logic [31:0]      in_ALUOut,
  input  logic [31:0]      in_NPC,
  input  logic             ld_valid,
  input  logic [31:0]      ld_data,
  output logic             WBFlag,
  output logic [4:0]       WBAddr,
  output logic [31:0]      WBVal,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {IDLE, WRITE, WAIT_LD} state_t;

  state_t      state;
  logic [4:0]  ld_dst;
  logic [5:0]  ld_op;
  logic [1:0]  ld_addr;

  logic [5:0]  op;
  logic [5:0]  fn;
  logic        dec_wr;
  logic        dec_ld;
  logic [4:0]  dec_dst;
  logic [31:0] dec_val;
  logic        accept;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_ext;

  assign op       = in_IR[31:26];
  assign fn       = in_IR[5:0];
  assign in_ready = (state != WAIT_LD);
  assign busy     = (state == WAIT_LD);
  assign accept   = in_valid && in_ready;

  always_comb begin
    dec_wr  = 1'b0;
    dec_ld  = 1'b0;
    dec_dst = 5'd0;
    dec_val = in_ALUOut;
    if (op == 6'h00) begin
      if (in_IR != 32'd0 && fn != 6'h08) begin
        dec_wr  = 1'b1;
        dec_dst = in_IR[15:11];
      end
    end else if (op >= 6'h08 && op <= 6'h0f) begin
      dec_wr  = 1'b1;
      dec_dst = in_IR[20:16];
    end else if (op == 6'h03) begin
      dec_wr  = 1'b1;
      dec_dst = 5'd31;
      dec_val = in_NPC;
    end else if (op == 6'h20 || op == 6'h21 || op == 6'h23 ||
                 op == 6'h24 || op == 6'h25) begin
      dec_ld  = 1'b1;
      dec_dst = in_IR[20:16];
    end
  end

  // Little-endian lane select; halfword accesses ignore addr[0].
  always_comb begin
    byte_sel = ld_data[8*ld_addr +: 8];
    half_sel = ld_addr[1] ? ld_data[31:16] : ld_data[15:0];
    case (ld_op)
      6'h20:   ld_ext = {{24{byte_sel[7]}}, byte_sel};
      6'h24:   ld_ext = {24'd0, byte_sel};
      6'h21:   ld_ext = {{16{half_sel[15]}}, half_sel};
      6'h25:   ld_ext = {16'd0, half_sel};
      default: ld_ext = ld_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      WBFlag  <= 1'b0;
      WBAddr  <= 5'd0;
      WBVal   <= 32'd0;
      retired <= '0;
      ld_dst  <= 5'd0;
      ld_op   <= 6'd0;
      ld_addr <= 2'd0;
    end else begin
      case (state)
        IDLE, WRITE: begin
          WBFlag <= 1'b0;
          state  <= IDLE;
          if (accept) begin
            retired <= retired + CNT_W'(1);
            if (dec_ld) begin
              state   <= WAIT_LD;
              ld_dst  <= dec_dst;
              ld_op   <= op;
              ld_addr <= in_ALUOut[1:0];
            end else if (dec_wr && dec_dst != 5'd0) begin
              state  <= WRITE;
              WBFlag <= 1'b1;
              WBAddr <= dec_dst;
              WBVal  <= dec_val;
            end
          end
        end
        WAIT_LD: begin
          WBFlag <= 1'b0;
          if (ld_valid) begin
            // A load into $0 still consumes its data beat but writes nothing.
            if (ld_dst != 5'd0) begin
              state  <= WRITE;
              WBFlag <= 1'b1;
              WBAddr <= ld_dst;
              WBVal  <= ld_ext;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state  <= IDLE;
          WBFlag <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_seg.sv
// tb/tb_wb_seg.sv - self-checking bench for wb_seg against a behavioural model
module tb_wb_seg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_IR = 32'd0;
  logic [31:0] in_ALUOut = 32'd0;
  logic [31:0] in_NPC = 32'd0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data = 32'd0;

  logic        in_ready, WBFlag, busy;
  logic [4:0]  WBAddr;
  logic [31:0] WBVal, retired;
  logic        in_ready4, WBFlag4, busy4;
  logic [4:0]  WBAddr4;
  logic [31:0] WBVal4;
  logic [3:0]  retired4;

  int tests = 0;
  int errors = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  wb_seg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_IR(in_IR), .in_ALUOut(in_ALUOut), .in_NPC(in_NPC),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .WBFlag(WBFlag), .WBAddr(WBAddr), .WBVal(WBVal),
    .busy(busy), .retired(retired)
  );

  wb_seg #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_IR(in_IR), .in_ALUOut(in_ALUOut), .in_NPC(in_NPC),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .WBFlag(WBFlag4), .WBAddr(WBAddr4), .WBVal(WBVal4),
    .busy(busy4), .retired(retired4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: instruction classes and load extraction by arithmetic.
  function automatic void classify(input logic [31:0] ir, output bit wr, output bit ld,
                                   output logic [4:0] dst);
    int o;
    o = ir[31:26];
    wr = 0; ld = 0; dst = 0;
    if (ir == 0) wr = 0;
    else if (o == 0 && ir[5:0] != 8) begin wr = 1; dst = ir[15:11]; end
    else if (o >= 8 && o <= 15) begin wr = 1; dst = ir[20:16]; end
    else if (o == 3) begin wr = 1; dst = 31; end
    else if (o == 'h20 || o == 'h21 || o == 'h23 || o == 'h24 || o == 'h25) begin
      ld = 1; dst = ir[20:16];
    end
  endfunction

  function automatic logic [31:0] extract(input int o, input int a, input logic [31:0] d);
    logic [31:0] v;
    case (o)
      'h20, 'h24: begin
        v = (d >> (8 * a)) & 32'hff;
        if (o == 'h20 && v >= 128) v = v - 256;
      end
      'h21, 'h25: begin
        v = (d >> (16 * (a / 2))) & 32'hffff;
        if (o == 'h21 && v >= 32768) v = v - 65536;
      end
      default: v = d;
    endcase
    return v;
  endfunction

  logic        m_pend, m_flag;
  logic [4:0]  m_dst, m_waddr;
  logic [31:0] m_wval, m_cnt;
  int          m_op, m_addr;

  always @(posedge clk or negedge rst) begin
    bit wr, ld;
    logic [4:0] d;
    if (!rst) begin
      m_pend <= 0; m_flag <= 0; m_waddr <= 0; m_wval <= 0; m_cnt <= 0;
      m_dst <= 0; m_op <= 0; m_addr <= 0;
    end else begin
      m_flag <= 0;
      if (m_pend) begin
        if (ld_valid) begin
          m_pend <= 0;
          if (m_dst != 0) begin
            m_flag <= 1; m_waddr <= m_dst; m_wval <= extract(m_op, m_addr, ld_data);
          end
        end
      end else if (in_valid) begin
        m_cnt <= m_cnt + 1;
        classify(in_IR, wr, ld, d);
        if (ld) begin
          m_pend <= 1; m_dst <= d; m_op <= int'(in_IR[31:26]); m_addr <= int'(in_ALUOut[1:0]);
        end else if (wr && d != 0) begin
          m_flag <= 1; m_waddr <= d; m_wval <= (in_IR[31:26] == 3) ? in_NPC : in_ALUOut;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready", {31'd0, in_ready}, {31'd0, !m_pend});
    check("busy", {31'd0, busy}, {31'd0, m_pend});
    check("WBFlag", {31'd0, WBFlag}, {31'd0, m_flag});
    check("WBAddr", {27'd0, WBAddr}, {27'd0, m_waddr});
    check("WBVal", WBVal, m_wval);
    check("retired", retired, m_cnt);
    check("retired4", {28'd0, retired4}, {28'd0, m_cnt[3:0]});
    if (rst && WBFlag) pulses <= pulses + 1;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] npc);
    in_valid = 1; in_IR = ir; in_ALUOut = alu; in_NPC = npc;
    step();
    in_valid = 0;
  endtask

  task automatic do_load(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] exp);
    send(ir, alu, 32'd0);
    for (int i = 0; i < 2; i++) begin
      check("ld_wait_ready", {31'd0, in_ready}, 32'd0);
      check("ld_wait_busy", {31'd0, busy}, 32'd1);
      step();
    end
    ld_data = 32'h80FF_7F01;
    ld_valid = 1;
    step();
    ld_valid = 0;
    ld_data = 32'h0;
    check("ld_flag", {31'd0, WBFlag}, 32'd1);
    check("ld_addr", {27'd0, WBAddr}, 32'd9);
    check("ld_val", WBVal, exp);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom); ld_valid = 1'($urandom);
      in_IR = $urandom; in_ALUOut = $urandom; in_NPC = $urandom; ld_data = $urandom;
      step();
      check("rst_flag", {31'd0, WBFlag}, 32'd0);
      check("rst_retired", retired, 32'd0);
      check("rst_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 0; ld_valid = 0; ld_data = 0;
    rst = 1;
    step();

    send(32'h2008_0005, 32'd5, 32'd0);
    check("addi_flag", {31'd0, WBFlag}, 32'd1);
    check("addi_addr", {27'd0, WBAddr}, 32'd8);
    check("addi_val", WBVal, 32'd5);
    step();

    send(32'h0022_1820, 32'h11, 32'd0);
    check("add_flag", {31'd0, WBFlag}, 32'd1);
    check("add_addr", {27'd0, WBAddr}, 32'd3);
    check("add_val", WBVal, 32'h11);
    send(32'h3404_0022, 32'h22, 32'd0);
    check("ori_flag", {31'd0, WBFlag}, 32'd1);
    check("ori_addr", {27'd0, WBAddr}, 32'd4);
    check("ori_val", WBVal, 32'h22);
    check("b2b_retired", retired, 32'd3);
    step();

    do_load(32'h8009_1003, 32'h1003, 32'hFFFF_FF80);
    do_load(32'h9009_1003, 32'h1003, 32'h0000_0080);
    do_load(32'h8409_1002, 32'h1002, 32'hFFFF_80FF);
    step();

    send(32'h0C00_0000, 32'd0, 32'h0040_0008);
    check("jal_addr", {27'd0, WBAddr}, 32'd31);
    check("jal_val", WBVal, 32'h0040_0008);
    send(32'hAC09_0000, 32'h40, 32'd0);
    send(32'h1000_0000, 32'h1, 32'd0);
    send(32'h0000_0000, 32'h2, 32'd0);
    send(32'h03E0_0008, 32'h3, 32'd0);
    send(32'h2000_0005, 32'h5, 32'd0);
    step();
    check("nowrite_pulses", pulses, 32'd7);
    check("nowrite_retired", retired, 32'd12);

    send(32'h8C0A_0000, 32'h2000, 32'd0);
    step();
    rst = 0;
    step();
    rst = 1;
    check("midrst_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_retired", retired, 32'd0);
    ld_data = 32'h1234_5678;
    ld_valid = 1;
    step();
    ld_valid = 0;
    step();
    check("late_ld_flag", {31'd0, WBFlag}, 32'd0);
    check("late_ld_pulses", pulses, 32'd7);

    in_IR = 32'd0; in_ALUOut = 32'd0;
    in_valid = 1;
    for (int i = 0; i < 17; i++) step();
    in_valid = 0;
    step();
    check("wrap_retired4", {28'd0, retired4}, 32'd1);
    check("wrap_retired32", retired, 32'd17);
    check("wrap_pulses", pulses, 32'd7);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
